// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32-entry architectural register file.
package regfile_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned IDX_WIDTH  = 5;
    localparam int unsigned WORD_WIDTH = 64;

    typedef logic [IDX_WIDTH-1:0]  reg_idx_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam reg_idx_t XZR_IDX = 5'd31;

endpackage : regfile_pkg

// File: rtl/regfile_32x64_decoder.sv
// decoder_5_32: write-enable decoder, a 1-to-2 stage on index[4] feeding two 4-to-16 decoders.
module decoder_5_32
    import regfile_pkg::*;
(
    input  reg_idx_t    index,
    input  logic        enable,
    output logic [31:0] onehot
);

    logic en_lo;
    logic en_hi;

    assign en_lo = enable & ~index[4];
    assign en_hi = enable &  index[4];

    // Each half decodes index[3:0] under its own enable from the 1-to-2 stage.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < 16; i++) begin
            onehot[i]      = en_lo & (index[3:0] == 4'(i));
            onehot[i + 16] = en_hi & (index[3:0] == 4'(i));
        end
    end

endmodule : decoder_5_32

// File: rtl/regfile_32x64.sv
// Architectural register file: X0-X30 in flops, XZR (index 31) reads as zero.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_32x64 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   reg_write,
    input  regfile_pkg::reg_idx_t  write_register,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  regfile_pkg::reg_idx_t  read_register1,
    input  regfile_pkg::reg_idx_t  read_register2,
    output logic [DATA_WIDTH-1:0]  read_data1,
    output logic [DATA_WIDTH-1:0]  read_data2
);

    import regfile_pkg::*;

    localparam int unsigned NUM_STORED = NUM_REGS - 1;

    logic [DATA_WIDTH-1:0] regs [NUM_STORED];
    logic [31:0]           we;
    logic                  unused_we_xzr;

    decoder_5_32 u_decoder (
        .index  (write_register),
        .enable (reg_write),
        .onehot (we)
    );

    // Decode bit 31 has no storage behind it; XZR writes vanish here.
    assign unused_we_xzr = we[31];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_STORED); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_STORED); i++) begin
                if (we[i]) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input reg_idx_t idx);
        logic [DATA_WIDTH-1:0] rd;
        rd = '0;
        for (int i = 0; i < int'(NUM_STORED); i++) begin
            if (idx == 5'(i)) begin
                rd = regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (reset_n && reg_write && (write_register != XZR_IDX) && (idx == write_register)) begin
            rd = write_data;
        end
`endif
        return rd;
    endfunction

    always_comb begin
        read_data1 = read_port(read_register1);
        read_data2 = read_port(read_register2);
    end

endmodule : regfile_32x64
